// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, field bit positions and exception codes.
package cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int IE_BIT     = 0;
    localparam int EXL_BIT    = 1;
    localparam int EXCCODE_LO = 2;
    localparam int IM_LO      = 10;
    localparam int BD_BIT     = 31;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// M-stage side of the CP0 exception controller: exception report, MTC0/MFC0/ERET and flush outputs.
interface cp0_exc_ctrl_if #(
    parameter int ADDR_W    = 32,
    parameter int NUM_HWINT = 6
);
    // No valid/ready pairs: every input is a single-cycle command qualified by its own strobe
    // (ExcValid, WE, EXLClr) and takes effect at the next rising edge; RData/EPCOut/ErrSignal/IntReq
    // are combinational and valid in the same cycle.
    logic [ADDR_W-1:0]    PCAddr;
    logic                 InBD;
    logic                 ExcValid;
    logic [4:0]           ExcCode;
    logic [NUM_HWINT-1:0] HWInt;
    logic                 WE;
    logic [4:0]           Addr;
    logic [31:0]          WData;
    logic                 EXLClr;
    logic [31:0]          RData;
    logic [ADDR_W-1:0]    EPCOut;
    logic                 ErrSignal;
    logic                 IntReq;

    modport master (
        output PCAddr, InBD, ExcValid, ExcCode, HWInt, WE, Addr, WData, EXLClr,
        input  RData, EPCOut, ErrSignal, IntReq
    );

    modport slave (
        input  PCAddr, InBD, ExcValid, ExcCode, HWInt, WE, Addr, WData, EXLClr,
        output RData, EPCOut, ErrSignal, IntReq
    );

endinterface

// File: rtl/cp0_int_sync.sv
// Multi-flop synchroniser for the asynchronous hardware interrupt lines.
module cp0_int_sync #(
    parameter int W      = 6,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] chain [STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: SR, Cause, EPC, PRId, interrupt arbitration and ERET target.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          NUM_HWINT   = 6,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] PRID_VAL    = 32'h2020_0707,
    parameter bit          EPC_BYPASS  = 1'b1
) (
    input logic         clk,
    input logic         reset,
    cp0_exc_ctrl_if.slave bus
);

    logic [NUM_HWINT-1:0] im;
    logic [NUM_HWINT-1:0] ip;
    logic                 ie;
    logic                 exl;
    logic                 bd;
    logic [4:0]           exc_code;
    logic [ADDR_W-1:0]    epc;

    logic                 int_req;
    logic                 exc_take;
    logic                 err;
    logic                 eret;
    logic                 mtc0;
    logic [ADDR_W-1:0]    epc_target;
    logic [31:0]          sr_word;
    logic [31:0]          cause_word;

    cp0_int_sync #(
        .W      (NUM_HWINT),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.HWInt),
        .q     (ip)
    );

    // Interrupts only see registered state, so IntReq never depends on this cycle's inputs.
    assign int_req  = (|(ip & im)) & ie & ~exl;
    assign exc_take = bus.ExcValid & ~exl;
    assign err      = int_req | exc_take;
    assign eret     = bus.EXLClr & ~err;
    assign mtc0     = bus.WE & ~err;

    // A delay-slot instruction restarts at its branch; subtraction wraps modulo 2^ADDR_W.
    assign epc_target = bus.InBD ? (bus.PCAddr - ADDR_W'(4)) : bus.PCAddr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im       <= '0;
            ie       <= 1'b0;
            exl      <= 1'b0;
            bd       <= 1'b0;
            exc_code <= '0;
            epc      <= '0;
        end else if (err) begin
            exl      <= 1'b1;
            bd       <= bus.InBD;
            epc      <= {epc_target[ADDR_W-1:2], 2'b00};
            exc_code <= int_req ? EXC_INT : bus.ExcCode;
        end else begin
            if (mtc0 && bus.Addr == CP0_SR) begin
                im  <= bus.WData[IM_LO +: NUM_HWINT];
                ie  <= bus.WData[IE_BIT];
                exl <= bus.WData[EXL_BIT] & ~bus.EXLClr;
            end else if (eret) begin
                exl <= 1'b0;
            end
            if (mtc0 && bus.Addr == CP0_EPC) begin
                epc <= {bus.WData[ADDR_W-1:2], 2'b00};
            end
        end
    end

    always_comb begin
        sr_word                          = '0;
        sr_word[IM_LO +: NUM_HWINT]      = im;
        sr_word[EXL_BIT]                 = exl;
        sr_word[IE_BIT]                  = ie;
        cause_word                       = '0;
        cause_word[BD_BIT]               = bd;
        cause_word[IM_LO +: NUM_HWINT]   = ip;
        cause_word[EXCCODE_LO +: 5]      = exc_code;
        case (bus.Addr)
            CP0_SR:    bus.RData = sr_word;
            CP0_CAUSE: bus.RData = cause_word;
            CP0_EPC:   bus.RData = 32'(epc);
            CP0_PRID:  bus.RData = PRID_VAL;
            default:   bus.RData = '0;
        endcase
    end

    // ERET in the same cycle as an MTC0 to EPC can return straight to the new value.
    assign bus.EPCOut    = (EPC_BYPASS && eret && mtc0 && bus.Addr == CP0_EPC)
                           ? ADDR_W'(bus.WData) : epc;
    assign bus.ErrSignal = err;
    assign bus.IntReq    = int_req;

endmodule
